seg_scan_rx: RTL and testbench

SEG_SCAN_RX -- requirements
Module: seg_scan_rx

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_decode.sv | 32 +++
 rtl/seg_scan_rx.sv | 138 +++++++++++++
 tb/tb_seg_scan_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan receiver:
// active-low segment codes, decode result codes and the scan FSM states.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // {g,f,e,d,c,b,a}, a segment is lit when its bit is 0
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic {
    TRACK  = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational active-low seven-segment pattern to hex digit decoder.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] value
);

  always_comb begin
    err   = 1'b0;
    value = CODE_ERR;
    case (seg)
      SEG_0:     value = 4'h0;
      SEG_1:     value = 4'h1;
      SEG_2:     value = 4'h2;
      SEG_3:     value = 4'h3;
      SEG_4:     value = 4'h4;
      SEG_5:     value = 4'h5;
      SEG_6:     value = 4'h6;
      SEG_7:     value = 4'h7;
      SEG_8:     value = 4'h8;
      SEG_9:     value = 4'h9;
      SEG_BLANK: value = CODE_BLANK;
      default: begin
        value = CODE_ERR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Recovers the 4-digit value shown by an external multiplexed 7-seg driver.
// Optional watchdog enabled by defining SEG_SCAN_RX_TIMEOUT_EN.
module seg_scan_rx
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        timeout
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("seg_scan_rx: STABLE_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("seg_scan_rx: TIMEOUT_CYCLES must be positive");
  end

  logic [6:0]  seg_s1, seg_s2;
  logic [3:0]  an_s1, an_s2;
  logic [10:0] prev;
  logic        changed;
  logic [7:0]  cnt, cnt_nx;
  state_t      st, st_nx;
  logic        accept, an_ok, wr, publish, wd_expire;
  logic        dec_err;
  logic [3:0]  dec_val;
  logic [NUM_DIGITS-1:0]      seen, slot_err;
  logic [NUM_DIGITS-1:0][3:0] slot_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1  <= '1;
      an_s2  <= '1;
      prev   <= '1;
      st     <= TRACK;
      cnt    <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
      prev   <= {an_s2, seg_s2};
      st     <= st_nx;
      cnt    <= cnt_nx;
    end
  end

  assign changed = ({an_s2, seg_s2} != prev);

  // The accept fires on the cycle the run length reaches STABLE_CYCLES.
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    accept = 1'b0;
    if (changed) begin
      st_nx  = TRACK;
      cnt_nx = 8'd1;
    end else if (st == TRACK) begin
      cnt_nx = cnt + 8'd1;
      if (cnt == 8'(STABLE_CYCLES - 1)) begin
        accept = 1'b1;
        st_nx  = LOCKED;
      end
    end
  end

  seg_decode u_dec (
    .seg   (seg_s2),
    .err   (dec_err),
    .value (dec_val)
  );

  assign an_ok   = $onehot(~an_s2);
  assign wr      = accept && an_ok;
  assign publish = &seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_val <= '0;
      slot_err <= '0;
    end else if (wr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_s2[i]) begin
          slot_val[i] <= dec_val;
          slot_err[i] <= dec_err;
        end
      end
    end
  end

  // Clear happens first so an accept in the publish cycle opens the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen        <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      seen        <= ((publish || wd_expire) ? '0 : seen) | (wr ? ~an_s2 : '0);
      frame_valid <= publish;
      if (publish) begin
        digits    <= slot_val;
        digit_err <= slot_err;
      end
    end
  end

`ifdef SEG_SCAN_RX_TIMEOUT_EN
  logic [31:0] wd;

  assign wd_expire = (wd == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= wd_expire;
      if (wr || wd_expire) wd <= '0;
      else                 wd <= wd + 32'd1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_rx.sv
// Directed self-checking bench for seg_scan_rx (STABLE_CYCLES=4).
module tb_seg_scan_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        timeout;

  int n_chk = 0;
  int n_fail = 0;
  int fv_count = 0;
  int to_count = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] BAD = 7'b0110110;

  seg_scan_rx #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (frame_valid) fv_count++;
    if (timeout) to_count++;
  end

  // Called at a negedge; inputs change immediately and are held n cycles.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an_in  = a;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    drive(4'b1111, BL, n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    an_in = 4'b1111;
    seg_in = BL;
    repeat (3) @(negedge clk);
    n_chk++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got %h want 0000", digits); end
    n_chk++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b want 0000", digit_err); end
    n_chk++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", frame_valid); end
    n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_basic;
    int fv0, lat;
    fv0 = fv_count;
    drive(4'b1110, D1, 10);
    drive(4'b1101, D2, 10);
    drive(4'b1011, D3, 10);
    n_chk++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL basic_partial got %h want 0000", digits); end
    an_in = 4'b0111;
    seg_in = D4;
    lat = 0;
    while (frame_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_chk++; if (lat !== 7) begin n_fail++; $display("FAIL basic_latency got %0d want 7", lat); end
    if (lat < 10) repeat (10 - lat) @(negedge clk);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL basic_frames got %0d want 1", fv_count - fv0); end
    n_chk++; if (digits !== 16'h4321) begin n_fail++; $display("FAIL basic_digits got %h want 4321", digits); end
    n_chk++; if (digit_err !== 4'h0) begin n_fail++; $display("FAIL basic_err got %b want 0000", digit_err); end
  endtask

  task automatic test_short_hold;
    int fv0;
    fv0 = fv_count;
    drive(4'b1110, D1, 10);
    drive(4'b1101, D2, 10);
    drive(4'b1011, D3, 3);
    drive(4'b1110, D5, 10);
    drive(4'b1101, D6, 10);
    drive(4'b1011, D7, 10);
    n_chk++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL short_early got %0d want 0", fv_count - fv0); end
    n_chk++; if (digits !== 16'h4321) begin n_fail++; $display("FAIL short_hold_old got %h want 4321", digits); end
    drive(4'b0111, D8, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL short_frames got %0d want 1", fv_count - fv0); end
    n_chk++; if (digits !== 16'h8765) begin n_fail++; $display("FAIL short_digits got %h want 8765", digits); end
  endtask

  task automatic test_err_blank;
    drive(4'b1110, D0, 10);
    drive(4'b1101, BAD, 10);
    drive(4'b1011, D0, 10);
    drive(4'b0111, D0, 10);
    idle(12);
    n_chk++; if (digits !== 16'h00F0) begin n_fail++; $display("FAIL err_digits got %h want 00f0", digits); end
    n_chk++; if (digit_err !== 4'b0010) begin n_fail++; $display("FAIL err_flags got %b want 0010", digit_err); end
    drive(4'b1110, D0, 10);
    drive(4'b1101, D0, 10);
    drive(4'b1011, D0, 10);
    drive(4'b0111, BL, 10);
    idle(12);
    n_chk++; if (digits !== 16'hE000) begin n_fail++; $display("FAIL blank_digits got %h want e000", digits); end
    n_chk++; if (digit_err !== 4'b0000) begin n_fail++; $display("FAIL blank_flags got %b want 0000", digit_err); end
  endtask

  task automatic test_bad_an;
    int fv0;
    fv0 = fv_count;
    drive(4'b1110, D1, 10);
    drive(4'b1100, D9, 20);
    drive(4'b1101, D2, 10);
    drive(4'b1011, D3, 10);
    drive(4'b0111, D4, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL badan_frames got %0d want 1", fv_count - fv0); end
    n_chk++; if (digits !== 16'h4321) begin n_fail++; $display("FAIL badan_digits got %h want 4321", digits); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    drive(4'b1110, D5, 10);
    drive(4'b1101, D6, 10);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    fv0 = fv_count;
    n_chk++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL rstmid_digits got %h want 0000", digits); end
    idle(6);
    drive(4'b1011, D7, 10);
    drive(4'b0111, D8, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL rstmid_partial got %0d want 0", fv_count - fv0); end
    n_chk++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL rstmid_hold got %h want 0000", digits); end
    drive(4'b1110, D1, 10);
    drive(4'b1101, D2, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL rstmid_frames got %0d want 1", fv_count - fv0); end
    n_chk++; if (digits !== 16'h8721) begin n_fail++; $display("FAIL rstmid_digits2 got %h want 8721", digits); end
  endtask

  task automatic test_back_to_back;
    int fv0;
    fv0 = fv_count;
    drive(4'b1110, D9, 10);
    drive(4'b1101, D0, 10);
    drive(4'b1011, D9, 10);
    drive(4'b0111, D9, 40);
    drive(4'b1110, D1, 10);
    drive(4'b1101, D1, 10);
    drive(4'b1011, D1, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 1) begin n_fail++; $display("FAIL held_frames got %0d want 1", fv_count - fv0); end
    n_chk++; if (digits !== 16'h9909) begin n_fail++; $display("FAIL held_digits got %h want 9909", digits); end
    // close the partial frame left open by the three trailing slots
    drive(4'b0111, D2, 10);
    idle(12);
    n_chk++; if (digits !== 16'h2111) begin n_fail++; $display("FAIL held_next got %h want 2111", digits); end
  endtask

`ifdef SEG_SCAN_RX_TIMEOUT_EN
  task automatic test_timeout;
    int fv0, to0;
    fv0 = fv_count;
    to0 = to_count;
    drive(4'b1110, D1, 10);
    drive(4'b1101, D2, 10);
    drive(4'b1011, D3, 10);
    idle(150);
    n_chk++; if (to_count - to0 !== 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want 1", to_count - to0); end
    drive(4'b0111, D4, 10);
    idle(12);
    n_chk++; if (fv_count - fv0 !== 0) begin n_fail++; $display("FAIL timeout_frames got %0d want 0", fv_count - fv0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short_hold();
    test_err_blank();
    test_bad_an();
    test_reset_mid();
    test_back_to_back();
`ifdef SEG_SCAN_RX_TIMEOUT_EN
    test_timeout();
`else
    n_chk++; if (to_count !== 0) begin n_fail++; $display("FAIL timeout_tied got %0d want 0", to_count); end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
